// File: rtl/mem_rr_arbiter_if.sv
// Request-side and memory-side signal bundle for mem_rr_arbiter.
// master is the arbiter's view; slave is the requesters plus the memory.
interface mem_rr_arbiter_if #(
    parameter int unsigned NUM_REQ     = 4,
    parameter int unsigned WIDTH       = 16,
    parameter int unsigned ADDR_WIDTH  = 9,
    parameter int unsigned GRANT_WIDTH = $clog2(NUM_REQ)
);
    logic [NUM_REQ-1:0]            req_valid;
    logic [NUM_REQ-1:0]            req_wr_rd;
    logic [NUM_REQ*ADDR_WIDTH-1:0] req_addr;
    logic [NUM_REQ*WIDTH-1:0]      req_wdata;
    logic [NUM_REQ-1:0]            req_ready;
    logic                          req_err;
    logic [WIDTH-1:0]              req_rdata;
    logic                          mem_valid;
    logic                          mem_wr_rd;
    logic [ADDR_WIDTH-1:0]         mem_addr;
    logic [WIDTH-1:0]              mem_wdata;
    logic [WIDTH-1:0]              mem_rdata;
    logic                          mem_ready;
    logic                          busy;
    logic [GRANT_WIDTH-1:0]        grant;

    modport master (
        input  req_valid, req_wr_rd, req_addr, req_wdata, mem_rdata, mem_ready,
        output req_ready, req_err, req_rdata, mem_valid, mem_wr_rd, mem_addr, mem_wdata,
        output busy, grant
    );

    modport slave (
        output req_valid, req_wr_rd, req_addr, req_wdata, mem_rdata, mem_ready,
        input  req_ready, req_err, req_rdata, mem_valid, mem_wr_rd, mem_addr, mem_wdata,
        input  busy, grant
    );
endinterface

// File: rtl/mem_rr_arbiter.sv
// Round-robin arbiter sharing one single-port memory among NUM_REQ requesters.
// Each transaction walks IDLE -> ISSUE -> WAIT -> DONE; WAIT ends on memory ready or timeout.
module mem_rr_arbiter #(
    parameter int unsigned NUM_REQ    = 4,
    parameter int unsigned WIDTH      = 16,
    parameter int unsigned DEPTH      = 512,
    parameter int unsigned ADDR_WIDTH = $clog2(DEPTH),
    parameter int unsigned TIMEOUT    = 15
) (
    input logic              clk_i,
    input logic              rst_ni,
    mem_rr_arbiter_if.master bus
);
    localparam int unsigned GW = $clog2(NUM_REQ);
    localparam int unsigned CW = $clog2(TIMEOUT) + 1;

    localparam logic [1:0] StIdle  = 2'd0;
    localparam logic [1:0] StIssue = 2'd1;
    localparam logic [1:0] StWait  = 2'd2;
    localparam logic [1:0] StDone  = 2'd3;

    logic [1:0]            state_q;
    logic [GW-1:0]         rr_q;
    logic [GW-1:0]         grant_q;
    logic [CW-1:0]         cnt_q;
    logic                  mem_valid_q;
    logic                  mem_wr_rd_q;
    logic [ADDR_WIDTH-1:0] mem_addr_q;
    logic [WIDTH-1:0]      mem_wdata_q;
    logic [NUM_REQ-1:0]    ready_q;
    logic                  err_q;
    logic [WIDTH-1:0]      rdata_q;

    logic                  found;
    logic [GW-1:0]         win;
    logic [GW-1:0]         sel;

    // First requester at or above the rr pointer, wrapping around.
    always_comb begin
        found = 1'b0;
        win   = '0;
        sel   = '0;
        for (int unsigned i = 0; i < NUM_REQ; i++) begin
            sel = GW'((32'(rr_q) + i) % NUM_REQ);
            if (!found && bus.req_valid[sel]) begin
                found = 1'b1;
                win   = sel;
            end
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            state_q     <= StIdle;
            rr_q        <= '0;
            grant_q     <= '0;
            cnt_q       <= '0;
            mem_valid_q <= 1'b0;
            mem_wr_rd_q <= 1'b0;
            mem_addr_q  <= '0;
            mem_wdata_q <= '0;
            ready_q     <= '0;
            err_q       <= 1'b0;
            rdata_q     <= '0;
        end else begin
            unique case (state_q)
                StIdle: begin
                    if (found) begin
                        grant_q     <= win;
                        mem_wr_rd_q <= bus.req_wr_rd[win];
                        mem_addr_q  <= bus.req_addr[32'(win)*ADDR_WIDTH +: ADDR_WIDTH];
                        mem_wdata_q <= bus.req_wdata[32'(win)*WIDTH +: WIDTH];
                        mem_valid_q <= 1'b1;
                        rr_q        <= GW'((32'(win) + 32'd1) % NUM_REQ);
                        state_q     <= StIssue;
                    end
                end
                StIssue: begin
                    mem_valid_q <= 1'b0;
                    cnt_q       <= '0;
                    state_q     <= StWait;
                end
                StWait: begin
                    if (bus.mem_ready) begin
                        ready_q[grant_q] <= 1'b1;
                        err_q            <= 1'b0;
                        rdata_q          <= mem_wr_rd_q ? '0 : bus.mem_rdata;
                        state_q          <= StDone;
                    end else if (cnt_q == CW'(TIMEOUT - 1)) begin
                        ready_q[grant_q] <= 1'b1;
                        err_q            <= 1'b1;
                        rdata_q          <= '0;
                        state_q          <= StDone;
                    end else begin
                        cnt_q <= cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    // rdata_q is left holding the last response.
                    ready_q <= '0;
                    err_q   <= 1'b0;
                    state_q <= StIdle;
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign bus.req_ready = ready_q;
    assign bus.req_err   = err_q;
    assign bus.req_rdata = rdata_q;
    assign bus.mem_valid = mem_valid_q;
    assign bus.mem_wr_rd = mem_wr_rd_q;
    assign bus.mem_addr  = mem_addr_q;
    assign bus.mem_wdata = mem_wdata_q;
    assign bus.busy      = (state_q != StIdle);
    assign bus.grant     = grant_q;
endmodule

// File: tb/tb_mem_rr_arbiter.sv
// Bench for mem_rr_arbiter: transaction-timestamp model checked every cycle,
// plus directed scenarios with hand-computed expectations.
module tb_mem_rr_arbiter;
    localparam int unsigned N     = 4;
    localparam int unsigned W     = 16;
    localparam int unsigned DEPTH = 512;
    localparam int unsigned AW    = 9;
    localparam int unsigned TO    = 15;

    logic clk = 1'b0;
    logic rst_n = 1'b0;
    always #5 clk = ~clk;

    mem_rr_arbiter_if #(.NUM_REQ(N), .WIDTH(W), .ADDR_WIDTH(AW)) bus ();

    mem_rr_arbiter #(
        .NUM_REQ(N), .WIDTH(W), .DEPTH(DEPTH), .ADDR_WIDTH(AW), .TIMEOUT(TO)
    ) dut (
        .clk_i (clk),
        .rst_ni(rst_n),
        .bus   (bus)
    );

    int passed = 0;
    int total = 0;
    int cyc = 0;
    bit chk_en = 1'b0;
    bit mem_silent = 1'b0;
    int rearm [N];
    int mv_cnt = 0;

    typedef struct { int cyc; logic [N-1:0] rdy; logic err; logic [W-1:0] rdata; } comp_t;
    typedef struct { int cyc; int g; } gr_t;
    comp_t comp_q[$];
    gr_t   grant_q[$];

    function automatic logic [W-1:0] init_val(int a);
        if (a < 4) return W'(32'h1000 + a);
        if (a == 170) return 16'h5555;
        return '0;
    endfunction

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act === exp) passed++;
        else $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    endtask

    // Behavioural memory: registered one-cycle response to each strobe.
    logic [W-1:0] mem [DEPTH];
    bit mem_init = 1'b0;
    always @(posedge clk) begin
        if (!mem_init) begin
            for (int i = 0; i < DEPTH; i++) mem[i] <= init_val(i);
            mem_init <= 1'b1;
            bus.mem_ready <= 1'b0;
            bus.mem_rdata <= '0;
        end else if (bus.mem_valid && !mem_silent) begin
            bus.mem_ready <= 1'b1;
            if (bus.mem_wr_rd) mem[bus.mem_addr] <= bus.mem_wdata;
            else bus.mem_rdata <= mem[bus.mem_addr];
        end else begin
            bus.mem_ready <= 1'b0;
        end
    end

    // Model: a granted transaction is described by its grant edge and completion edge.
    logic [W-1:0]  ref_mem [DEPTH];
    bit            m_busy = 0, m_ans = 0, m_wr = 0;
    int            m_g = 0, m_done = -10, m_win = 0, m_ptr = 0;
    logic [AW-1:0] m_addr = '0;
    logic [W-1:0]  m_wdata = '0, m_rd_val = '0;
    logic [N-1:0]  e_ready = '0;
    logic          e_err = 0, e_mem_valid = 0, e_mem_wr = 0, e_busy = 0;
    logic [W-1:0]  e_rdata = '0, e_mem_wdata = '0;
    logic [AW-1:0] e_mem_addr = '0;
    int            e_grant = 0;

    initial begin
        for (int i = 0; i < DEPTH; i++) ref_mem[i] = init_val(i);
        forever begin
            @(posedge clk);
            cyc++;
            if (m_busy && cyc == m_g + 1) begin
                m_ans    = !mem_silent;
                m_rd_val = ref_mem[m_addr];
                if (m_ans && m_wr) ref_mem[m_addr] = m_wdata;
                m_done = m_ans ? m_g + 2 : m_g + int'(TO) + 1;
            end
            if (!rst_n) begin
                m_busy = 0; m_ptr = 0; e_ready = '0; e_err = 0; e_rdata = '0;
                e_mem_valid = 0; e_mem_wr = 0; e_mem_addr = '0; e_mem_wdata = '0;
                e_busy = 0; e_grant = 0;
            end else if (m_busy) begin
                if (cyc == m_g + 1) e_mem_valid = 0;
                if (cyc == m_done) begin
                    e_ready = '0;
                    e_ready[m_win] = 1'b1;
                    e_err = !m_ans;
                    e_rdata = (m_ans && !m_wr) ? m_rd_val : '0;
                end else if (cyc == m_done + 1) begin
                    e_ready = '0; e_err = 0; e_busy = 0; m_busy = 0;
                end
            end else begin
                for (int k = 0; k < int'(N); k++) begin
                    int c;
                    c = (m_ptr + k) % int'(N);
                    if (!m_busy && bus.req_valid[c]) begin
                        m_busy = 1; m_g = cyc; m_win = c;
                        m_wr = bus.req_wr_rd[c];
                        m_addr = bus.req_addr[c*AW +: AW];
                        m_wdata = bus.req_wdata[c*W +: W];
                        e_grant = c; e_mem_valid = 1; e_mem_wr = m_wr;
                        e_mem_addr = m_addr; e_mem_wdata = m_wdata; e_busy = 1;
                        m_ptr = (c + 1) % int'(N);
                    end
                end
            end
        end
    end

    // Compare process and transaction logs.
    initial forever begin
        @(negedge clk);
        if (chk_en) begin
            chk("req_ready", 32'(bus.req_ready), 32'(e_ready));
            chk("req_err", 32'(bus.req_err), 32'(e_err));
            chk("req_rdata", 32'(bus.req_rdata), 32'(e_rdata));
            chk("mem_valid", 32'(bus.mem_valid), 32'(e_mem_valid));
            chk("mem_wr_rd", 32'(bus.mem_wr_rd), 32'(e_mem_wr));
            chk("mem_addr", 32'(bus.mem_addr), 32'(e_mem_addr));
            chk("mem_wdata", 32'(bus.mem_wdata), 32'(e_mem_wdata));
            chk("busy", 32'(bus.busy), 32'(e_busy));
            chk("grant", 32'(bus.grant), 32'(e_grant));
        end
        if (bus.req_ready != '0) comp_q.push_back('{cyc, bus.req_ready, bus.req_err, bus.req_rdata});
        if (bus.mem_valid) begin
            grant_q.push_back('{cyc, int'(bus.grant)});
            mv_cnt++;
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
        for (int k = 0; k < int'(N); k++) begin
            if (bus.req_ready[k]) begin
                if (rearm[k] > 0) rearm[k]--;
                else bus.req_valid[k] = 1'b0;
            end
        end
    endtask

    task automatic set_req(input int k, input bit wr, input int addr, input int data);
        bus.req_wr_rd[k] = wr;
        bus.req_addr[k*AW +: AW] = AW'(addr);
        bus.req_wdata[k*W +: W] = W'(data);
        bus.req_valid[k] = 1'b1;
    endtask

    task automatic wait_idle(input string name);
        int n;
        n = 0;
        do begin
            tick();
            n++;
        end while ((bus.req_valid != '0 || bus.busy) && n < 200);
        if (n >= 200) begin
            total++;
            $display("FAIL %s: no completion within 200 cycles", name);
        end
    endtask

    function automatic comp_t last_comp();
        comp_t c;
        c.cyc = -1; c.rdy = '0; c.err = 1'b1; c.rdata = '1;
        if (comp_q.size() > 0) c = comp_q[$];
        return c;
    endfunction

    initial begin
        comp_t c;
        int t0, g0, n0;
        int exp_g [5] = '{0, 1, 2, 3, 0};
        for (int k = 0; k < int'(N); k++) rearm[k] = 0;
        bus.req_valid = '0; bus.req_wr_rd = '0; bus.req_addr = '0; bus.req_wdata = '0;

        rst_n = 1'b0;
        tick(); chk_en = 1'b1; tick(); tick();
        chk("rst_busy", 32'(bus.busy), 0);
        chk("rst_ready", 32'(bus.req_ready), 0);
        chk("rst_mem_valid", 32'(bus.mem_valid), 0);
        chk("rst_grant", 32'(bus.grant), 0);
        rst_n = 1'b1;

        // Single write then read from requester 2.
        tick(); t0 = cyc; n0 = comp_q.size();
        set_req(2, 1, 'h1A5, 'hBEEF);
        wait_idle("wr");
        c = last_comp();
        chk("wr_count", 32'(comp_q.size() - n0), 1);
        chk("wr_latency", 32'(c.cyc - t0), 3);
        chk("wr_ready", 32'(c.rdy), 32'b0100);
        chk("wr_err", 32'(c.err), 0);
        set_req(2, 0, 'h1A5, 0);
        wait_idle("rd");
        c = last_comp();
        chk("rd_rdata", 32'(c.rdata), 32'hBEEF);
        chk("rd_err", 32'(c.err), 0);

        // Round robin from pointer 0, requester 0 asks twice.
        rst_n = 1'b0; tick(); tick(); rst_n = 1'b1;
        g0 = grant_q.size(); n0 = comp_q.size();
        for (int k = 0; k < 4; k++) set_req(k, 0, k, 0);
        rearm[0] = 1;
        wait_idle("rr");
        chk("rr_count", 32'(grant_q.size() - g0), 5);
        if (grant_q.size() - g0 == 5 && comp_q.size() - n0 == 5) begin
            for (int i = 0; i < 5; i++) begin
                chk("rr_grant", 32'(grant_q[g0+i].g), 32'(exp_g[i]));
                chk("rr_rdata", 32'(comp_q[n0+i].rdata), 32'h1000 + 32'(exp_g[i]));
                if (i > 0) chk("rr_spacing", 32'(grant_q[g0+i].cyc - grant_q[g0+i-1].cyc), 4);
            end
        end

        // Pointer to 3 via requester 2, then 0 and 3 compete.
        set_req(2, 0, 0, 0);
        wait_idle("ptr");
        g0 = grant_q.size();
        set_req(0, 0, 1, 0);
        set_req(3, 0, 2, 0);
        wait_idle("fair");
        chk("fair_count", 32'(grant_q.size() - g0), 2);
        if (grant_q.size() - g0 == 2) begin
            chk("fair_first", 32'(grant_q[g0].g), 3);
            chk("fair_second", 32'(grant_q[g0+1].g), 0);
        end

        // Silent memory forces a timeout completion.
        mem_silent = 1'b1;
        set_req(1, 0, 5, 0);
        wait_idle("to");
        c = last_comp();
        chk("to_err", 32'(c.err), 1);
        chk("to_rdata", 32'(c.rdata), 0);
        chk("to_ready", 32'(c.rdy), 32'b0010);
        chk("to_latency", 32'(c.cyc - grant_q[$].cyc), 16);
        mem_silent = 1'b0;
        set_req(1, 0, 2, 0);
        wait_idle("after_to");
        c = last_comp();
        chk("after_to_rdata", 32'(c.rdata), 32'h1002);
        chk("after_to_err", 32'(c.err), 0);

        // Write completion masks rdata after a read.
        set_req(0, 0, 170, 0);
        wait_idle("mask_rd");
        c = last_comp();
        chk("mask_rd_rdata", 32'(c.rdata), 32'h5555);
        set_req(0, 1, 170, 'h1234);
        wait_idle("mask_wr");
        c = last_comp();
        chk("mask_wr_rdata", 32'(c.rdata), 0);
        chk("mask_wr_err", 32'(c.err), 0);

        // Reset during WAIT drops the transaction; the held request is re-served.
        mem_silent = 1'b1;
        n0 = comp_q.size();
        set_req(3, 0, 3, 0);
        repeat (4) tick();
        rst_n = 1'b0;
        repeat (3) tick();
        chk("midrst_busy", 32'(bus.busy), 0);
        chk("midrst_ready", 32'(bus.req_ready), 0);
        chk("midrst_mem_valid", 32'(bus.mem_valid), 0);
        chk("midrst_err", 32'(bus.req_err), 0);
        chk("midrst_rdata", 32'(bus.req_rdata), 0);
        chk("midrst_no_comp", 32'(comp_q.size() - n0), 0);
        rst_n = 1'b1;
        mem_silent = 1'b0;
        wait_idle("reissue");
        c = last_comp();
        chk("reissue_rdata", 32'(c.rdata), 32'h1003);
        chk("reissue_ready", 32'(c.rdy), 32'b1000);
        chk("strobe_cycles", 32'(mv_cnt), 16);

        tick();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end
endmodule
